// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared FSM state, midscale level
// and default widths for the tone sequencer slice.
package tone_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  localparam logic [7:0] MIDSCALE = 8'h80;

  localparam int NUM_TONES_D = 8;
  localparam int ADDR_W_D    = 8;
  localparam int SAMPLE_W_D  = 8;
  localparam int DIV_W_D     = 16;
  localparam int DUR_W_D     = 25;

endpackage

// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: control, config, ROM and DAC
// signals between the top level and the sequencer.
interface tone_sequencer_if
  import tone_seq_pkg::*;
#(
  parameter int NUM_TONES = NUM_TONES_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int SAMPLE_W  = SAMPLE_W_D,
  parameter int DIV_W     = DIV_W_D,
  parameter int DUR_W     = DUR_W_D
);
  localparam int IDX_W = $clog2(NUM_TONES);
  localparam int LEN_W = IDX_W + 1;

  logic                start;
  logic                stop;
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic [DIV_W-1:0]    cfg_div;
  logic [DUR_W-1:0]    cfg_dur;
  logic                cfg_len_we;
  logic [LEN_W-1:0]    cfg_len;
  logic [ADDR_W-1:0]   rom_addr;
  logic [SAMPLE_W-1:0] rom_q;
  logic [SAMPLE_W-1:0] sample_out;
  logic [IDX_W-1:0]    tone_idx;
  logic                busy;
  logic                done;

  modport master (
    output start, stop,
    output cfg_we, cfg_idx, cfg_div, cfg_dur,
    output cfg_len_we, cfg_len,
    output rom_q,
    input  rom_addr, sample_out, tone_idx,
    input  busy, done
  );

  modport slave (
    input  start, stop,
    input  cfg_we, cfg_idx, cfg_div, cfg_dur,
    input  cfg_len_we, cfg_len,
    input  rom_q,
    output rom_addr, sample_out, tone_idx,
    output busy, done
  );

endinterface

// File: rtl/tone_divider.sv
// tone_divider: reloadable cycles-per-sample counter;
// a zero divider is a rest and never ticks.
module tone_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_en,
  output logic             o_tick,
  output logic             o_rest
);
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  assign o_rest = (r_div == '0);
  assign o_tick = i_en && !o_rest && (r_cnt == '0);

  // latch the divider on load, then count down and reload on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div - DIV_W'(1);
    end else if (i_en && !o_rest) begin
      if (o_tick) r_cnt <= r_div - DIV_W'(1);
      else        r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps the sine ROM through a tone table.
// Define TONE_LOOP_EN to repeat the sequence until stop.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int NUM_TONES = NUM_TONES_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int SAMPLE_W  = SAMPLE_W_D,
  parameter int DIV_W     = DIV_W_D,
  parameter int DUR_W     = DUR_W_D
) (
  input logic         CLOCK_25,
  input logic         reset_n,
  tone_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_TONES);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN =
    LEN_W'(NUM_TONES);
  localparam logic [SAMPLE_W-1:0] MID =
    SAMPLE_W'(MIDSCALE);

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_W-1:0]    r_tab_div [NUM_TONES];
  logic [DUR_W-1:0]    r_tab_dur [NUM_TONES];
  logic [LEN_W-1:0]    r_len;
  logic [IDX_W-1:0]    r_idx;
  logic [DUR_W-1:0]    r_dur_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_done;

  logic             w_busy;
  logic             w_play;
  logic             w_skip;
  logic             w_end;
  logic             w_last;
  logic             w_load;
  logic [IDX_W-1:0] w_load_idx;
  logic             w_wrap;
  logic             w_done_nxt;
  logic             w_tick;
  logic             w_rest;
  logic             w_tick_eff;

  assign w_busy = (r_state == PLAY);
  assign w_play = w_busy && !bus.stop;
  assign w_skip = (r_dur_cnt == '0);
  assign w_end  = (r_dur_cnt <= DUR_W'(1));
  assign w_last = ({1'b0, r_idx} == r_len - LEN_W'(1));

  assign w_tick_eff = w_tick && !w_skip;

  tone_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (CLOCK_25),
    .rst_n  (reset_n),
    .i_load (w_load),
    .i_div  (r_tab_div[w_load_idx]),
    .i_en   (w_busy),
    .o_tick (w_tick),
    .o_rest (w_rest)
  );

  // state register
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // next state, entry load and end-of-sequence decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = '0;
    w_wrap      = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (r_len != '0) begin
            w_state_nxt = PLAY;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.stop) begin
          w_state_nxt = IDLE;
        end else if (w_end && !w_last) begin
          w_load     = 1'b1;
          w_load_idx = r_idx + IDX_W'(1);
        end else if (w_end) begin
          w_wrap     = 1'b1;
          w_done_nxt = 1'b1;
`ifdef TONE_LOOP_EN
          w_load     = 1'b1;
`else
          w_state_nxt = DONE;
`endif
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // tone table and length, writable only while idle
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TONES; i++) begin
        r_tab_div[i] <= '0;
        r_tab_dur[i] <= '0;
      end
      r_len <= '0;
    end else if (r_state == IDLE) begin
      if (bus.cfg_we &&
          ({1'b0, bus.cfg_idx} < MAX_LEN)) begin
        r_tab_div[bus.cfg_idx] <= bus.cfg_div;
        r_tab_dur[bus.cfg_idx] <= bus.cfg_dur;
      end
      if (bus.cfg_len_we) begin
        r_len <= (bus.cfg_len > MAX_LEN) ?
                 MAX_LEN : bus.cfg_len;
      end
    end
  end

  // current entry, duration countdown and done pulse
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_dur_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_idx     <= w_load_idx;
        r_dur_cnt <= r_tab_dur[w_load_idx];
      end else if (w_busy && !w_skip) begin
        r_dur_cnt <= r_dur_cnt - DUR_W'(1);
      end
    end
  end

  // ROM address stepping and DAC sample register
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_sample <= MID;
    end else if (w_play) begin
      if (w_tick_eff)             r_sample <= bus.rom_q;
      else if (w_rest && !w_skip) r_sample <= MID;
      if (w_load || w_wrap)       r_addr <= '0;
      else if (w_tick_eff)        r_addr <= r_addr + ADDR_W'(1);
    end else begin
      r_addr   <= '0;
      r_sample <= MID;
    end
  end

  assign bus.rom_addr   = r_addr;
  assign bus.sample_out = r_sample;
  assign bus.tone_idx   = r_idx;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and random tone tables
// checked against a per-entry arithmetic model.
module tb_tone_sequencer;
  import tone_seq_pkg::*;

  localparam int NT = 8;

  logic clk = 1'b0;
  logic rst_n;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int m_div [NT];
  int m_dur [NT];
  logic [7:0] q_samp [$];

  tone_sequencer_if #(.NUM_TONES(NT)) bus ();

  tone_sequencer #(.NUM_TONES(NT)) dut (
    .CLOCK_25 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  function automatic logic [7:0] rom_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  always @(posedge clk)
    bus.rom_q <= rom_val(int'(bus.rom_addr));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr_ent(input int i, input int d,
                        input int u);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 3'(i);
    bus.cfg_div = 16'(d);
    bus.cfg_dur = 25'(u);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_div[i] = d;
    m_dur[i] = u;
  endtask

  task automatic wr_len(input int l);
    bus.cfg_len_we = 1'b1;
    bus.cfg_len    = 4'(l);
    @(negedge clk);
    bus.cfg_len_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Play n entries of m_div/m_dur; cs enables sample
  // checks, spam drives config writes while playing.
  task automatic run_seq(input int n, input bit cs,
                         input bit spam);
    int carry;
    int d;
    int u;
    int L;
    int m;
    logic [7:0] es;
    pulse_start();
    carry = 128;
    for (int i = 0; i < n; i++) begin
      d = m_div[i];
      u = m_dur[i];
      L = (u == 0) ? 1 : u;
      for (int j = 0; j < L; j++) begin
        if (spam) begin
          bus.cfg_we     = 1'b1;
          bus.cfg_idx    = 3'(i);
          bus.cfg_div    = 16'd7;
          bus.cfg_dur    = 25'd1;
          bus.cfg_len_we = 1'b1;
          bus.cfg_len    = 4'd1;
        end
        m = (d == 0 || u == 0) ? 0 : j / d;
        if (u == 0)       es = 8'(carry);
        else if (d == 0)  es = (j == 0) ? 8'(carry) : 8'h80;
        else if (m == 0)  es = 8'(carry);
        else              es = rom_val(m - 1);
        chk("busy", bus.busy, 1);
        chk("tone_idx", bus.tone_idx, i);
        chk("rom_addr", bus.rom_addr, m % 256);
        chk("done_play", bus.done, 0);
        if (cs) chk("sample", bus.sample_out, es);
        q_samp.push_back(bus.sample_out);
        @(negedge clk);
      end
      if (u != 0) begin
        if (d == 0)          carry = 128;
        else if (L / d > 0)  carry = rom_val(L / d - 1);
      end
    end
    bus.cfg_we     = 1'b0;
    bus.cfg_len_we = 1'b0;
`ifdef TONE_LOOP_EN
    chk("loop_busy", bus.busy, 1);
    chk("loop_done", bus.done, 1);
    chk("loop_idx", bus.tone_idx, 0);
    chk("loop_addr", bus.rom_addr, 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("loop_stop_busy", bus.busy, 0);
    chk("loop_stop_done", bus.done, 0);
    chk("loop_stop_samp", bus.sample_out, 8'h80);
`else
    chk("end_busy", bus.busy, 0);
    chk("end_done", bus.done, 1);
    chk("end_addr", bus.rom_addr, 0);
    if (cs) chk("end_samp", bus.sample_out, carry);
    @(negedge clk);
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_samp", bus.sample_out, 8'h80);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, bus.rom_addr, 0);
    chk({tag, "_samp"}, bus.sample_out, 8'h80);
    chk({tag, "_idx"}, bus.tone_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v;
    bit found;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = '0;
    bus.cfg_div    = '0;
    bus.cfg_dur    = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    pulse_start();
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    @(negedge clk);
    chk("len0_done2", bus.done, 0);
    chk("len0_busy2", bus.busy, 0);

    wr_ent(0, 4, 40);
    wr_len(1);
    run_seq(1, 1'b1, 1'b0);

    wr_ent(0, 2, 10);
    wr_ent(1, 0, 6);
    wr_ent(2, 3, 9);
    wr_len(3);
    run_seq(3, 1'b1, 1'b0);

    wr_ent(0, 3, 4);
    wr_ent(1, 2, 0);
    wr_ent(2, 0, 3);
    wr_len(3);
    run_seq(3, 1'b1, 1'b0);
    run_seq(3, 1'b1, 1'b1);
    run_seq(3, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        v = $urandom_range(0, 5);
        wr_ent(i, (v == 0) ? 0 : v + 1,
               $urandom_range(0, 10));
      end
      wr_len(n);
      run_seq(n, 1'b1, 1'b0);
    end

    for (int i = 0; i < NT; i++)
      wr_ent(i, 2 + i % 3, $urandom_range(1, 5));
    wr_len(15);
    run_seq(NT, 1'b1, 1'b0);

    wr_ent(0, 1, 300);
    wr_len(1);
    q_samp.delete();
    run_seq(1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k + 1 < q_samp.size(); k++)
      if (q_samp[k] == rom_val(255) &&
          q_samp[k + 1] == rom_val(0))
        found = 1'b1;
    chk("wrap_samp", found, 1);

    wr_ent(0, 3, 60);
    wr_len(1);
    pulse_start();
    repeat (15) @(negedge clk);
    chk("stop_pre_busy", bus.busy, 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_busy", bus.busy, 0);
    chk("stop_samp", bus.sample_out, 8'h80);
    chk("stop_addr", bus.rom_addr, 0);
    chk("stop_done", bus.done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stop_nodone", bus.done, 0);
    end

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("ss_busy", bus.busy, 0);
    chk("ss_done", bus.done, 0);
    @(negedge clk);
    chk("ss_busy2", bus.busy, 0);

    wr_ent(0, 2, 100);
    wr_len(1);
    pulse_start();
    repeat (9) @(negedge clk);
    chk("mid_addr", bus.rom_addr, 4);
    #5;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("rst_len0_done", bus.done, 1);
    chk("rst_len0_busy", bus.busy, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
